// File: rtl/fa_exhaustive_checker.sv
// Purpose: self-test sweep of a 1-bit full adder over all 8 input vectors, counting mismatches against golden S/Cout.
// Latency: each vector held SETTLE_CYCLES cycles; verdict (done/pass) 8*SETTLE_CYCLES cycles after the start edge.
// Backpressure: none; start is honoured only in IDLE or DONE and ignored while a sweep runs.
module fa_exhaustive_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       x1_o,
    output logic       x2_o,
    output logic       cin_o,
    input  logic       s_i,
    input  logic       cout_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic       fail_valid,
    output logic [2:0] first_fail_vec
);

    // Counter value on which the adder response is judged.
    localparam logic [3:0] HOLD_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [2:0] r_vec;
    logic [3:0] r_hold;
    logic [3:0] r_err_count;
    logic       r_fail_valid;
    logic [2:0] r_first_fail_vec;

    logic       w_start_ok;
    logic       w_judge;
    logic       w_last_vec;
    logic       w_exp_s;
    logic       w_exp_cout;
    logic       w_mismatch;
    logic       w_busy;
    logic       w_done;

    // A new sweep may only begin when no sweep is in flight.
    assign w_start_ok = start && (r_state != ST_RUN);
    assign w_judge    = (r_state == ST_RUN) && (r_hold == HOLD_LAST);
    assign w_last_vec = (r_vec == 3'd7);

    // Golden full-adder response for the vector currently being driven.
    assign w_exp_s    = r_vec[2] ^ r_vec[1] ^ r_vec[0];
    assign w_exp_cout = (r_vec[2] & r_vec[1]) | (r_vec[2] & r_vec[0]) | (r_vec[1] & r_vec[0]);
    // One count per vector even if both bits are wrong.
    assign w_mismatch = (s_i != w_exp_s) || (cout_i != w_exp_cout);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: the judgement of vector 7 ends the sweep.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_judge && w_last_vec) w_state_nxt = ST_DONE;
            ST_DONE: if (start) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state; busy and done are mutually exclusive.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_RUN:  w_busy = 1'b1;
            ST_DONE: w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Sweep datapath: vector/hold counters and result capture on each judgement edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec            <= 3'd0;
            r_hold           <= 4'd0;
            r_err_count      <= 4'd0;
            r_fail_valid     <= 1'b0;
            r_first_fail_vec <= 3'd0;
        end else if (w_start_ok) begin
            r_vec            <= 3'd0;
            r_hold           <= 4'd0;
            r_err_count      <= 4'd0;
            r_fail_valid     <= 1'b0;
            r_first_fail_vec <= 3'd0;
        end else if (r_state == ST_RUN) begin
            if (w_judge) begin
                r_hold <= 4'd0;
                // Vector 7 is left on the drive pins after the sweep.
                if (!w_last_vec) begin
                    r_vec <= r_vec + 3'd1;
                end
                if (w_mismatch) begin
                    r_err_count <= r_err_count + 4'd1;
                    if (!r_fail_valid) begin
                        r_fail_valid     <= 1'b1;
                        r_first_fail_vec <= r_vec;
                    end
                end
            end else begin
                r_hold <= r_hold + 4'd1;
            end
        end
    end

    assign x1_o           = r_vec[2];
    assign x2_o           = r_vec[1];
    assign cin_o          = r_vec[0];
    assign busy           = w_busy;
    assign done           = w_done;
    assign pass           = w_done && (r_err_count == 4'd0);
    assign err_count      = r_err_count;
    assign fail_valid     = r_fail_valid;
    assign first_fail_vec = r_first_fail_vec;

endmodule

// File: tb/tb_fa_exhaustive_checker.sv
// Bench for fa_exhaustive_checker: two instances (SETTLE_CYCLES 2 and 1), each beside a configurable adder model.
// Drive sequences and final verdicts are predicted by a bench model and queued at start, then popped as the DUT produces them.
// Adder modes: 0 correct, 1 S stuck at 0, 2 Cout inverted, 3 one register stage.
module tb_fa_exhaustive_checker;

    typedef struct packed {
        logic [3:0] err;
        logic       fv;
        logic [2:0] ffv;
        logic       pass;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst     = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    int   mode    = 0;
    int   dsel    = 0;

    int errors = 0;
    int checks = 0;

    res_t       exp_q[$];
    logic [2:0] vec_q[$];
    logic [2:0] last_a = 3'd0;
    logic [2:0] last_b = 3'd0;

    logic       x1_a, x2_a, cin_a, s_a, cout_a, busy_a, done_a, pass_a, fv_a;
    logic [3:0] err_a;
    logic [2:0] ffv_a;
    logic       x1_b, x2_b, cin_b, s_b, cout_b, busy_b, done_b, pass_b, fv_b;
    logic [3:0] err_b;
    logic [2:0] ffv_b;

    fa_exhaustive_checker #(.SETTLE_CYCLES(2)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .x1_o(x1_a), .x2_o(x2_a), .cin_o(cin_a),
        .s_i(s_a), .cout_i(cout_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_valid(fv_a), .first_fail_vec(ffv_a)
    );

    fa_exhaustive_checker #(.SETTLE_CYCLES(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .x1_o(x1_b), .x2_o(x2_b), .cin_o(cin_b),
        .s_i(s_b), .cout_i(cout_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_valid(fv_b), .first_fail_vec(ffv_b)
    );

    // {s, cout} of a correct full adder
    function automatic logic [1:0] golden(input logic [2:0] v);
        logic s, c;
        s = v[2] ^ v[1] ^ v[0];
        c = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
        return {s, c};
    endfunction

    function automatic logic [1:0] faulty(input int m, input logic [2:0] v);
        logic [1:0] r;
        r = golden(v);
        if (m == 1) r[1] = 1'b0;
        if (m == 2) r[0] = ~r[0];
        return r;
    endfunction

    // Adder models
    logic [1:0] q_a, q_b, resp_a, resp_b;
    always @(posedge clk) begin
        q_a <= golden({x1_a, x2_a, cin_a});
        q_b <= golden({x1_b, x2_b, cin_b});
    end
    always_comb begin
        resp_a = (mode == 3) ? q_a : faulty(mode, {x1_a, x2_a, cin_a});
        resp_b = (mode == 3) ? q_b : faulty(mode, {x1_b, x2_b, cin_b});
    end
    assign s_a    = resp_a[1];
    assign cout_a = resp_a[0];
    assign s_b    = resp_b[1];
    assign cout_b = resp_b[0];

    // Selected-instance view
    logic [2:0] m_drv, m_ffv;
    logic [3:0] m_err;
    logic       m_busy, m_done, m_pass, m_fv;
    always_comb begin
        if (dsel == 0) begin
            m_drv = {x1_a, x2_a, cin_a}; m_busy = busy_a; m_done = done_a; m_pass = pass_a;
            m_err = err_a; m_fv = fv_a; m_ffv = ffv_a;
        end else begin
            m_drv = {x1_b, x2_b, cin_b}; m_busy = busy_b; m_done = done_b; m_pass = pass_b;
            m_err = err_b; m_fv = fv_b; m_ffv = ffv_b;
        end
    end

    // Predicted verdict; with a registered adder and one settle cycle each vector sees the previous vector's response.
    function automatic res_t model(input int m, input int s, input logic [2:0] prior);
        res_t       r;
        logic [1:0] resp;
        logic [2:0] v, pv;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            v  = 3'(k);
            pv = (k == 0) ? prior : 3'(k - 1);
            if (m == 3) resp = (s == 1) ? golden(pv) : golden(v);
            else        resp = faulty(m, v);
            if (resp !== golden(v)) begin
                r.err = r.err + 4'd1;
                if (!r.fv) begin
                    r.fv  = 1'b1;
                    r.ffv = v;
                end
            end
        end
        r.pass = (r.err == 4'd0);
        return r;
    endfunction

    task automatic set_start(input int sel, input logic val);
        if (sel == 0) start_a = val;
        else          start_b = val;
    endtask

    task automatic run_sweep(input string tag, input int sel, input int m, input int s, input int inj);
        res_t       e, got;
        logic [2:0] ev;
        dsel = sel;
        mode = m;
        e = model(m, s, (sel == 0) ? last_a : last_b);
        exp_q.push_back(e);
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < s; j++) vec_q.push_back(3'(k));
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        checks++;
        if ({m_busy, m_done, m_pass, m_err, m_fv, m_ffv} !== {1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL %s start_clear: got busy=%b done=%b err=%0d fv=%b ffv=%0d, want busy=1 done=0 err=0 fv=0 ffv=0",
                     tag, m_busy, m_done, m_err, m_fv, m_ffv);
        end
        for (int i = 0; i < 8 * s; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            set_start(sel, i == inj);
            ev = vec_q.pop_front();
            checks++;
            if (m_drv !== ev || m_busy !== 1'b1 || m_done !== 1'b0) begin
                errors++;
                $display("FAIL %s drive[%0d]: got vec=%0d busy=%b done=%b, want vec=%0d busy=1 done=0",
                         tag, i, m_drv, m_busy, m_done, ev);
            end
        end
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        got = exp_q.pop_front();
        checks++;
        if (m_done !== 1'b1 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_edge: got done=%b busy=%b, want done=1 busy=0", tag, m_done, m_busy);
        end
        checks++;
        if ({m_err, m_fv, m_ffv, m_pass} !== got) begin
            errors++;
            $display("FAIL %s verdict: got err=%0d fv=%b ffv=%0d pass=%b, want err=%0d fv=%b ffv=%0d pass=%b",
                     tag, m_err, m_fv, m_ffv, m_pass, got.err, got.fv, got.ffv, got.pass);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (m_done !== 1'b1 || m_busy !== 1'b0 || m_drv !== 3'd7 || {m_err, m_fv, m_ffv, m_pass} !== got) begin
            errors++;
            $display("FAIL %s done_hold: got done=%b busy=%b vec=%0d err=%0d, want done=1 busy=0 vec=7 err=%0d",
                     tag, m_done, m_busy, m_drv, m_err, got.err);
        end
        if (sel == 0) last_a = 3'd7;
        else          last_b = 3'd7;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({x1_a, x2_a, cin_a, busy_a, done_a, pass_a, err_a, fv_a, ffv_a} !== 14'd0) begin
            errors++;
            $display("FAIL reset_a: got outputs=%b, want all 0",
                     {x1_a, x2_a, cin_a, busy_a, done_a, pass_a, err_a, fv_a, ffv_a});
        end
        checks++;
        if ({x1_b, x2_b, cin_b, busy_b, done_b, pass_b, err_b, fv_b, ffv_b} !== 14'd0) begin
            errors++;
            $display("FAIL reset_b: got outputs=%b, want all 0",
                     {x1_b, x2_b, cin_b, busy_b, done_b, pass_b, err_b, fv_b, ffv_b});
        end
        last_a = 3'd0;
        last_b = 3'd0;
    endtask

    task automatic test_clean();
        run_sweep("clean_s1", 1, 0, 1, -1);
        run_sweep("clean_s2", 0, 0, 2, -1);
    endtask

    task automatic test_s_stuck();
        run_sweep("s_stuck", 0, 1, 2, -1);
    endtask

    task automatic test_start_in_done();
        // DUT a is in DONE with four errors; a new start must clear them.
        run_sweep("cout_inv_from_done", 0, 2, 2, -1);
    endtask

    task automatic test_registered();
        run_sweep("reg_s2", 0, 3, 2, -1);
        run_sweep("reg_s1", 1, 3, 1, -1);
        checks++;
        if (pass_b !== 1'b0 || err_b === 4'd0) begin
            errors++;
            $display("FAIL reg_s1_detect: got pass=%b err=%0d, want pass=0 err!=0", pass_b, err_b);
        end
    endtask

    task automatic test_start_ignored();
        run_sweep("start_in_run", 0, 0, 2, 3);
    endtask

    task automatic test_mid_reset();
        dsel = 0;
        mode = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if ({x1_a, x2_a, cin_a} !== 3'd3 || busy_a !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre: got vec=%0d busy=%b, want vec=3 busy=1", {x1_a, x2_a, cin_a}, busy_a);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({x1_a, x2_a, cin_a, busy_a, done_a, pass_a, err_a, fv_a, ffv_a} !== 14'd0) begin
            errors++;
            $display("FAIL mid_reset: got outputs=%b, want all 0",
                     {x1_a, x2_a, cin_a, busy_a, done_a, pass_a, err_a, fv_a, ffv_a});
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_idle: got busy=%b done=%b, want 0 0", busy_a, done_a);
        end
        last_a = 3'd0;
        last_b = 3'd0;
        run_sweep("after_reset", 0, 0, 2, -1);
    endtask

    initial begin
        test_reset();
        test_clean();
        test_s_stuck();
        test_start_in_done();
        test_registered();
        test_start_ignored();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
